// File: rtl/evm_pkg.sv
// Types and default widths shared by the ballot storage and the tally readout logic.
package evm_pkg;
   localparam int EVM_CAND_W = 4;
   localparam int EVM_CNT_W  = 4;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      WAIT,
      SEND,
      FINISH
   } tally_state_e;
endpackage

// File: rtl/tally_max_tracker.sv
// Running maximum, winner, tie and total accumulators for one tally scan.
module tally_max_tracker #(
   parameter int CAND_W = 4,
   parameter int CNT_W  = 4,
   parameter int TOT_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic              first,
   input  logic [CAND_W-1:0] idx,
   input  logic [CNT_W-1:0]  data,
   output logic [CNT_W-1:0]  max_cnt,
   output logic [CAND_W-1:0] win,
   output logic              tie,
   output logic [TOT_W-1:0]  total
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_cnt <= '0;
         win     <= '0;
         tie     <= 1'b0;
         total   <= '0;
      end else if (clr) begin
         max_cnt <= '0;
         win     <= '0;
         tie     <= 1'b0;
         total   <= '0;
      end else if (en) begin
         total <= total + TOT_W'(data);
         // The first candidate seeds the maximum so an all-zero scan still yields winner 0.
         if (first || (data > max_cnt)) begin
            max_cnt <= data;
            win     <= idx;
            tie     <= 1'b0;
         end else if (data == max_cnt) begin
            tie <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/tally_readout_unit.sv
// Scans every candidate's stored vote count, streams the pairs out and publishes the result.
module tally_readout_unit
   import evm_pkg::*;
#(
   parameter int NUM_CAND = 4,
   parameter int CAND_W   = EVM_CAND_W,
   parameter int CNT_W    = EVM_CNT_W,
   parameter int TOT_W    = CNT_W + $clog2(NUM_CAND)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              rd_en,
   output logic [CAND_W-1:0] rd_addr,
   input  logic [CNT_W-1:0]  rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CAND_W-1:0] out_cand,
   output logic [CNT_W-1:0]  out_count,
   output logic              busy,
   output logic              done,
   output logic [CAND_W-1:0] winner,
   output logic              tie,
   output logic              no_votes,
   output logic [TOT_W-1:0]  total
);

   localparam logic [CAND_W-1:0] LAST_IDX = CAND_W'(NUM_CAND - 1);

   tally_state_e      state_q, state_d;
   logic [CAND_W-1:0] idx;
   logic              accept;
   logic              last;
   logic [CNT_W-1:0]  trk_max;
   logic [CAND_W-1:0] trk_win;
   logic              trk_tie;
   logic [TOT_W-1:0]  trk_total;

   assign accept = (state_q == SEND) && out_ready;
   assign last   = (idx == LAST_IDX);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = READ;
         READ:    state_d = WAIT;
         WAIT:    state_d = SEND;
         SEND:    if (accept) state_d = last ? FINISH : READ;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign rd_en     = (state_q == READ);
   assign rd_addr   = (state_q == READ) ? idx : '0;
   assign out_valid = (state_q == SEND);
   assign busy      = (state_q == READ) || (state_q == WAIT) || (state_q == SEND);
   assign done      = (state_q == FINISH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         idx       <= '0;
         out_cand  <= '0;
         out_count <= '0;
         winner    <= '0;
         tie       <= 1'b0;
         no_votes  <= 1'b0;
         total     <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && start) begin
            idx <= '0;
         end else if (accept && !last) begin
            idx <= idx + 1'b1;
         end
         if (state_q == WAIT) begin
            out_cand  <= idx;
            out_count <= rd_data;
         end
         // Results latch on the final acceptance so they are already stable while done is high.
         if (accept && last) begin
            winner   <= trk_win;
            tie      <= trk_tie;
            no_votes <= (trk_max == '0);
            total    <= trk_total;
         end
      end
   end

   tally_max_tracker #(
      .CAND_W (CAND_W),
      .CNT_W  (CNT_W),
      .TOT_W  (TOT_W)
   ) u_max_tracker (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     ((state_q == IDLE) && start),
      .en      (state_q == WAIT),
      .first   (idx == '0),
      .idx     (idx),
      .data    (rd_data),
      .max_cnt (trk_max),
      .win     (trk_win),
      .tie     (trk_tie),
      .total   (trk_total)
   );

endmodule
